// File: rtl/des_pkg.sv
// Shared DES tables, permutation helpers and the engine state encoding.
// Latency: pure constants and combinational functions, no clocked logic.
// Backpressure: not applicable.
package des_pkg;

    localparam int DES_ROUNDS = 16;
    localparam int RND_W      = $clog2(DES_ROUNDS + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} eng_state_t;

    // All tables hold 1-based DES bit numbers; DES bit 1 is the MSB of a vector.
    localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                                 62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                                 57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                                 61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                                 38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                                 36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                                 34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                                12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                                24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                  10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                  63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                  14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                  23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                  41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                  44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Per-round rotate amounts; decrypt rotates right, starting from the full-turn key.
    localparam int ENC_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int DEC_SHIFT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // S-boxes: 4 rows x 16 columns of nibbles, entry {row,col} at nibble index row*16+col from MSB.
    localparam logic [255:0] SBOX_T [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] des_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] des_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] des_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] des_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] des_e(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] des_p(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
        return y;
    endfunction

    // Outer bits select the row, inner four bits the column.
    function automatic logic [3:0] des_sbox(input int n, input logic [5:0] x);
        int idx;
        idx = int'({x[5], x[0], x[4:1]});
        return SBOX_T[n][255 - 4*idx -: 4];
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        x = des_e(r) ^ k;
        for (int i = 0; i < 8; i++) s[31 - 4*i -: 4] = des_sbox(i, x[47 - 6*i -: 6]);
        return des_p(s);
    endfunction

endpackage

// File: rtl/des_round.sv
// One Feistel round with its key-schedule step: rotate C/D, PC2, f, swap halves.
// Latency: combinational, zero cycles.
// Backpressure: none; the owning engine decides when results are registered.
module des_round
    import des_pkg::*;
(
    input  logic [31:0]      l_in,
    input  logic [31:0]      r_in,
    input  logic [27:0]      c_in,
    input  logic [27:0]      d_in,
    input  logic             decrypt,
    input  logic [RND_W-1:0] rnd_idx,
    output logic [31:0]      l_out,
    output logic [31:0]      r_out,
    output logic [27:0]      c_out,
    output logic [27:0]      d_out
);

    logic [3:0]  sidx;
    logic [1:0]  sh;
    logic [47:0] k;

    // Rotate C and D for this round, derive the subkey, then apply the Feistel step.
    always_comb begin
        // Round 16 wraps to table slot 15 through the 4-bit truncation.
        sidx  = rnd_idx[3:0] - 4'd1;
        sh    = decrypt ? 2'(DEC_SHIFT[sidx]) : 2'(ENC_SHIFT[sidx]);
        c_out = c_in;
        d_out = d_in;
        case ({decrypt, sh})
            3'b001: begin c_out = {c_in[26:0], c_in[27]};    d_out = {d_in[26:0], d_in[27]};    end
            3'b010: begin c_out = {c_in[25:0], c_in[27:26]}; d_out = {d_in[25:0], d_in[27:26]}; end
            3'b101: begin c_out = {c_in[0], c_in[27:1]};     d_out = {d_in[0], d_in[27:1]};     end
            3'b110: begin c_out = {c_in[1:0], c_in[27:2]};   d_out = {d_in[1:0], d_in[27:2]};   end
            default: ;
        endcase
        k     = des_pc2({c_out, d_out});
        l_out = r_in;
        r_out = l_in ^ des_f(r_in, k);
    end

endmodule

// File: rtl/des_iter_engine.sv
// Iterative DES engine: IP, 16 rounds at UNROLL rounds per clock, then FP into a result register.
// Latency: 16/UNROLL + 1 cycles from the accept edge to out_valid; one block in flight at a time.
// Backpressure: result waits in DONE until out_ready; in_ready stays low until that handshake.
module des_iter_engine
    import des_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
        $error("des_iter_engine: UNROLL must be 1, 2, 4, 8 or 16");
    end

    eng_state_t       state_q, state_d;
    logic [31:0]      l_q, r_q;
    logic [27:0]      c_q, d_q;
    logic             mode_q;
    logic [RND_W-1:0] rnd_q;
    logic             last_step;

    logic [31:0] l_ch [UNROLL+1];
    logic [31:0] r_ch [UNROLL+1];
    logic [27:0] c_ch [UNROLL+1];
    logic [27:0] d_ch [UNROLL+1];

    assign l_ch[0]   = l_q;
    assign r_ch[0]   = r_q;
    assign c_ch[0]   = c_q;
    assign d_ch[0]   = d_q;
    assign last_step = (rnd_q == RND_W'(DES_ROUNDS - UNROLL));

    // Rounds rnd+1 .. rnd+UNROLL chained combinationally within one clock.
    for (genvar j = 0; j < UNROLL; j++) begin : g_round
        des_round u_round (
            .l_in    (l_ch[j]),
            .r_in    (r_ch[j]),
            .c_in    (c_ch[j]),
            .d_in    (d_ch[j]),
            .decrypt (mode_q),
            .rnd_idx (rnd_q + RND_W'(j + 1)),
            .l_out   (l_ch[j+1]),
            .r_out   (r_ch[j+1]),
            .c_out   (c_ch[j+1]),
            .d_out   (d_ch[j+1])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_step) state_d = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Block load on accept, round advance in RUN, result capture after round 16 (no final swap).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            mode_q   <= 1'b0;
            rnd_q    <= '0;
            out_data <= '0;
        end else if (state_q == S_IDLE && in_valid) begin
            {l_q, r_q} <= des_ip(in_data);
            {c_q, d_q} <= des_pc1(in_key);
            mode_q     <= in_decrypt;
            rnd_q      <= '0;
        end else if (state_q == S_RUN) begin
            l_q   <= l_ch[UNROLL];
            r_q   <= r_ch[UNROLL];
            c_q   <= c_ch[UNROLL];
            d_q   <= d_ch[UNROLL];
            rnd_q <= rnd_q + RND_W'(UNROLL);
            if (last_step) out_data <= des_fp({r_ch[UNROLL], l_ch[UNROLL]});
        end
    end

endmodule

// File: tb/tb_des_iter_engine.sv
// Scoreboard bench for des_iter_engine at UNROLL 1, 4 and 16 side by side.
// Latency: checks accept-to-out_valid of 16/UNROLL+1 and back-to-back spacing of 16/UNROLL+2.
// Backpressure: holds out_ready low for 20 cycles with a second block waiting at the input.
module tb_des_iter_engine;
    import des_pkg::*;

    localparam int ND = 3;
    localparam int UNR [ND] = '{1, 4, 16};

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] Z1 = 64'h8CA64DE9C1B123A7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid   [ND];
    logic        in_ready   [ND];
    logic        in_decrypt [ND];
    logic [63:0] in_data    [ND];
    logic [63:0] in_key     [ND];
    logic        out_valid  [ND];
    logic        out_ready  [ND];
    logic [63:0] out_data   [ND];
    logic        busy       [ND];

    int          n_vec;
    int          n_err;
    logic [63:0] exp_q [$];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        des_iter_engine #(.UNROLL(UNR[g])) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_decrypt (in_decrypt[g]),
            .in_data    (in_data[g]),
            .in_key     (in_key[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_data   (out_data[g]),
            .busy       (busy[g])
        );
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    // Reference: full key schedule first, decrypt walks the subkeys backwards.
    function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] data, input logic dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [63:0] x;
        logic [31:0] l, r, t;
        cd = des_pc1(key);
        c  = cd[55:28];
        d  = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < ENC_SHIFT[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[i] = des_pc2({c, d});
        end
        x = des_ip(data);
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ des_f(r, ks[dec ? 15 - i : i]);
            l = t;
        end
        return des_fp({r, l});
    endfunction

    task automatic drive(input int d, input logic [63:0] key, input logic [63:0] data, input logic dec);
        in_key[d]     = key;
        in_data[d]    = data;
        in_decrypt[d] = dec;
        in_valid[d]   = 1'b1;
    endtask

    // Called at a negedge with in_valid up; returns at the negedge after the accept edge.
    task automatic wait_accept(input int d, input string tag);
        int n;
        n = 0;
        while (!in_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_accept"}, 64'(in_ready[d]), 64'd1);
        @(negedge clk);
        in_valid[d]   = 1'b0;
        in_key[d]     = ~in_key[d];
        in_data[d]    = ~in_data[d];
        in_decrypt[d] = ~in_decrypt[d];
    endtask

    // Counts edges from the accept edge (inclusive) until out_valid, then scores the result.
    task automatic wait_result(input int d, input string tag);
        int          lat;
        logic [63:0] want;
        lat = 1;
        while (!out_valid[d] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (exp_q.size() > 0) want = exp_q.pop_front();
        else                  want = 'x;
        check_eq({tag, "_data"}, out_data[d], want);
        check_eq({tag, "_lat"}, 64'(lat), 64'(16 / UNR[d] + 1));
    endtask

    task automatic check_idle(input int d, input string tag);
        check_eq({tag, "_idle"}, 64'({out_valid[d], in_ready[d], busy[d]}), 64'(3'b010));
    endtask

    task automatic run_block(input int d, input logic [63:0] key, input logic [63:0] data,
                             input logic dec, input logic [63:0] want, input string tag);
        exp_q.push_back(want);
        out_ready[d] = 1'b1;
        drive(d, key, data, dec);
        wait_accept(d, tag);
        wait_result(d, tag);
        @(negedge clk);
        check_idle(d, tag);
    endtask

    task automatic backpressure(input int d, input string t);
        exp_q.push_back(C1);
        out_ready[d] = 1'b0;
        drive(d, K1, P1, 1'b0);
        wait_accept(d, {t, "_bp1"});
        wait_result(d, {t, "_bp1"});
        exp_q.push_back(Z1);
        drive(d, 64'd0, 64'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq({t, "_bp_hold_data"}, out_data[d], C1);
            check_eq({t, "_bp_hold_flags"}, 64'({out_valid[d], in_ready[d], busy[d]}), 64'(3'b101));
        end
        out_ready[d] = 1'b1;
        wait_accept(d, {t, "_bp2"});
        wait_result(d, {t, "_bp2"});
        @(negedge clk);
        check_idle(d, {t, "_bp2"});
    endtask

    task automatic back_to_back(input int d, input string t);
        int period;
        period = 16 / UNR[d] + 2;
        out_ready[d] = 1'b1;
        fork
            begin
                logic [63:0] key, dat;
                logic        dec;
                for (int k = 0; k < 8; k++) begin
                    key = {$urandom, $urandom};
                    dat = {$urandom, $urandom};
                    dec = 1'($urandom_range(0, 1));
                    exp_q.push_back(des_ref(key, dat, dec));
                    drive(d, key, dat, dec);
                    wait_accept(d, {t, "_b2b"});
                end
            end
            begin
                int cyc, last, got;
                logic [63:0] want;
                cyc  = 0;
                last = 0;
                got  = 0;
                while (got < 8 && cyc < 600) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid[d]) begin
                        if (exp_q.size() > 0) want = exp_q.pop_front();
                        else                  want = 'x;
                        check_eq({t, "_b2b_data"}, out_data[d], want);
                        if (got > 0) check_eq({t, "_b2b_period"}, 64'(cyc - last), 64'(period));
                        last = cyc;
                        got++;
                    end
                end
                check_eq({t, "_b2b_count"}, 64'(got), 64'd8);
            end
        join
        in_valid[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_mid_run();
        drive(0, K1, P1, 1'b0);
        wait_accept(0, "rst_mid");
        repeat (4) @(negedge clk);
        check_eq("rst_mid_running", 64'({out_valid[0], in_ready[0], busy[0]}), 64'(3'b001));
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_flags", 64'({out_valid[0], in_ready[0], busy[0]}), 64'(3'b010));
        check_eq("rst_mid_data", out_data[0], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_block(0, K1, P1, 1'b0, C1, "rst_after");
    endtask

    initial begin
        string t;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            in_valid[d]   = 1'b0;
            in_decrypt[d] = 1'b0;
            in_data[d]    = '0;
            in_key[d]     = '0;
            out_ready[d]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            t = $sformatf("u%0d", UNR[d]);
            check_idle(d, {t, "_reset"});
            check_eq({t, "_reset_data"}, out_data[d], 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int d = 0; d < ND; d++) begin
            t = $sformatf("u%0d", UNR[d]);
            run_block(d, K1, P1, 1'b0, C1, {t, "_enc"});
            run_block(d, K1, C1, 1'b1, P1, {t, "_dec"});
            run_block(d, 64'd0, 64'd0, 1'b0, Z1, {t, "_zero"});
            run_block(d, 64'h0101010101010101, 64'd0, 1'b0, Z1, {t, "_parity"});
            backpressure(d, t);
            back_to_back(d, t);
        end

        reset_mid_run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
